trace_buffer: RTL and testbench
===============================

# trace_buffer

Elastic FIFO placed directly downstream of `trace_unit`. It captures each `trace_output` record when `trace_data_ready` pulses and presents stored records in order on a valid/ready stream to the trace sink (a UART or debug-port drain). The buffer absorbs bursts of retired instructions while the sink stalls. When the buffer is full, it drops new records and flags the loss, so the core is never back-pressured.

## Interface
- `DEPTH`, 16, number of records stored; power of two, ≥ 2
- `ALMOST_FULL_MARGIN`, 2, `almost_full` asserts when `level ≥ DEPTH - ALMOST_FULL_MARGIN`; range 1..DEPTH-1
- `DROP_WIDTH`, 16, width of the drop counter
- `clk`  in  1  clock
- `rst`  in  1  reset (see note after this list)
- `flush`  in  1  synchronous clear of contents and status
- `trace_valid_i`  in  1  driven from `trace_unit.trace_data_ready`; one record per high cycle
- `trace_data_i`  in  `$bits(trace_output)`  record (`ryuki_datatypes::trace_output`)
- `out_valid`  out  1  head record available
- `out_ready`  in  1  sink accepts head record
- `out_data`  out  `$bits(trace_output)`  head record; all zero while `out_valid` = 0
- `level`  out  `$clog2(DEPTH)+1`  records currently held
- `almost_full`  out  1  level threshold reached
- `overflow`  out  1  sticky; at least one record dropped since reset or flush
- `drop_count`  out  `DROP_WIDTH`  dropped-record count, saturating

Reset and clock (already decided): reset `rst`, asynchronous, active-high; clock `clk`.

## Operation
- Storage is a circular array with `wr_ptr` and `rd_ptr`, each `$clog2(DEPTH)` bits. Both pointers wrap naturally from DEPTH-1 to 0.
- `level` is a separate counter, so full and empty are unambiguous:
  - full: `level == DEPTH`
  - empty: `level == 0`
- Push condition: `trace_valid_i && (!full || pop)`.
  - On push, write `mem[wr_ptr]` and increment `wr_ptr`.
- Pop condition: `out_valid && out_ready`.
  - On pop, increment `rd_ptr`.
- Level update:
  - push without pop: +1
  - pop without push: -1
  - both: unchanged
- Full with a simultaneous pop: the push is accepted; `level` stays DEPTH.
- Empty with `trace_valid_i` high: the push is accepted. There is no bypass, so the record is not visible in the same cycle.
- Drop condition: `trace_valid_i && full && !pop`. On drop:
  - the record is discarded
  - `overflow` is set to 1
  - `drop_count` increments and saturates at all-ones
- Output behaviour:
  - `out_valid` = `(level != 0)`
  - `out_data` = `mem[rd_ptr]` gated by `out_valid` (first-word fall-through)
- `flush` has priority over push, pop and drop in the same cycle. It sets:
  - `wr_ptr`, `rd_ptr` and `level` to 0
  - `overflow` to 0
  - `drop_count` to 0
  - A record arriving in the flush cycle is discarded and not counted.
- `almost_full` is combinational from `level`.

## Timing
- Reset values (asynchronous, immediate):
  - `out_valid` = 0
  - `out_data` = 0
  - `level` = 0
  - `almost_full` = 0
  - `overflow` = 0
  - `drop_count` = 0
  - pointers = 0
  - memory contents are not reset
- Reset asserted mid-operation discards all held records. Pops in progress are abandoned, and the sink must treat `out_valid` falling as the end of the stream.
- Latency: a record sampled at rising edge N is presented on `out_valid` and `out_data` in the cycle after edge N, provided the buffer was empty.
- Handshake:
  - A transfer completes on the edge where `out_valid && out_ready`.
  - While `out_ready` is low, `out_data` is held stable.
  - `out_valid` never drops without a pop, except on `flush` or `rst`.
- Throughput: one push and one pop per cycle, sustained indefinitely.
- `level`, `overflow` and `drop_count` update on the same edge as the event that changes them.

## Configuration
- `GODAI_TRACE_DROP_CNT_EN`
  - Defined: the `drop_count` register exists and behaves as described above.
  - Undefined: no `drop_count` register is built. The port remains and is tied to 0. `overflow` still operates.

## Test plan
- DEPTH=16, push records 0..15 back-to-back with `out_ready` = 0 -> `level` = 16, `almost_full` high from level 14, then `out_ready` = 1 drains 0..15 in order with no bubbles.
- Buffer full, 5 further pushes with `out_ready` = 0 -> `overflow` = 1, `drop_count` = 5, contents unchanged.
- Buffer full, push and pop in the same cycle -> push accepted, `level` stays 16, no drop counted.
- Continuous push and pop for 40 cycles -> pointers wrap twice, output order equals input order, `level` constant.
- `flush` asserted with `level` = 7, `drop_count` = 3 and `trace_valid_i` high -> next cycle `level` = 0, `out_valid` = 0, `drop_count` = 0, `overflow` = 0.
- `rst` pulsed asynchronously mid-drain with `level` = 9 -> all outputs 0 before the next edge; the buffer resumes correctly after release.

Source files
------------

// File: rtl/trace_buffer.sv
// Elastic first-word-fall-through FIFO between trace_unit and a trace sink; drops and counts records when full.
// Optional: define GODAI_TRACE_DROP_CNT_EN to build the saturating drop_count register (otherwise tied to 0).
module trace_buffer #(
    parameter int DEPTH              = 16,
    parameter int ALMOST_FULL_MARGIN = 2,
    parameter int DROP_WIDTH         = 16,
    parameter int TRACE_WIDTH        = 64     // $bits(ryuki_datatypes::trace_output)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       trace_valid_i,
    input  logic [TRACE_WIDTH-1:0]     trace_data_i,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [TRACE_WIDTH-1:0]     out_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       almost_full,
    output logic                       overflow,
    output logic [DROP_WIDTH-1:0]      drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] AF_L    = LW'(DEPTH - ALMOST_FULL_MARGIN);

    logic [TRACE_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;

    logic full;
    logic push;
    logic pop;
    logic drop;

    assign full = (level_q == DEPTH_L);
    assign pop  = out_valid && out_ready;
    // flush wins over everything: an arriving record is neither stored nor counted
    assign push = trace_valid_i && (!full || pop) && !flush;
    assign drop = trace_valid_i && full && !pop && !flush;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop)      level_d = level_q + LW'(1);
            else if (pop && !push) level_d = level_q - LW'(1);
            if (drop) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately not reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= trace_data_i;
    end

`ifdef GODAI_TRACE_DROP_CNT_EN
    logic [DROP_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (flush)
            drop_cnt_d = '0;
        else if (drop && (drop_cnt_q != {DROP_WIDTH{1'b1}}))
            drop_cnt_d = drop_cnt_q + DROP_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) drop_cnt_q <= '0;
        else     drop_cnt_q <= drop_cnt_d;
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = '0;
`endif

    assign out_valid   = (level_q != '0);
    assign out_data    = out_valid ? mem[rd_ptr_q] : '0;
    assign level       = level_q;
    assign almost_full = (level_q >= AF_L);
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_trace_buffer.sv
// Directed bench for trace_buffer: fill/drain, overflow, full push+pop, wrap, flush and async reset.
module tb_trace_buffer;

`ifdef GODAI_TRACE_DROP_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        trace_valid_i = 1'b0;
    logic [63:0] trace_data_i = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic [4:0]  level;
    logic        almost_full;
    logic        overflow;
    logic [15:0] drop_count;

    int checks = 0;
    int failures = 0;

    trace_buffer #(
        .DEPTH(16), .ALMOST_FULL_MARGIN(2), .DROP_WIDTH(16), .TRACE_WIDTH(64)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .trace_valid_i(trace_valid_i), .trace_data_i(trace_data_i),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level), .almost_full(almost_full),
        .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    function automatic logic [63:0] rec(input int i);
        return 64'hC0DE_0000_0000_0000 | 64'(i);
    endfunction

    // Inputs are changed at the falling edge; outputs are checked there too.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_data"},  out_data, 64'd0);
        check({tag, "_level"}, 64'(level), 64'd0);
        check({tag, "_af"},    64'(almost_full), 64'd0);
        check({tag, "_ovf"},   64'(overflow), 64'd0);
        check({tag, "_drop"},  64'(drop_count), 64'd0);
    endtask

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #1 check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Fill 0..15 with sink stalled
        for (int i = 0; i < 16; i++) begin
            trace_valid_i = 1'b1;
            trace_data_i  = rec(i);
            step();
            check($sformatf("fill%0d_level", i), 64'(level), 64'(i + 1));
            check($sformatf("fill%0d_af", i), 64'(almost_full), 64'(i + 1 >= 14));
            if (i == 0) begin
                check("first_valid", 64'(out_valid), 64'd1);
                check("first_data", out_data, rec(0));
            end
        end

        // Five pushes into a full buffer are dropped
        for (int j = 0; j < 5; j++) begin
            trace_data_i = rec(100 + j);
            step();
        end
        check("drop_ovf", 64'(overflow), 64'd1);
        check("drop_cnt", 64'(drop_count), CNT_EN ? 64'd5 : 64'd0);
        check("drop_level", 64'(level), 64'd16);
        check("drop_head", out_data, rec(0));

        // Full with simultaneous push and pop
        trace_data_i = rec(16);
        out_ready    = 1'b1;
        step();
        check("fullpp_level", 64'(level), 64'd16);
        check("fullpp_cnt", 64'(drop_count), CNT_EN ? 64'd5 : 64'd0);
        check("fullpp_head", out_data, rec(1));

        // Drain with no bubbles: records 1..16
        trace_valid_i = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check($sformatf("drain%0d_valid", k), 64'(out_valid), 64'd1);
            check($sformatf("drain%0d_data", k), out_data, rec(k + 1));
            step();
        end
        check("drained_level", 64'(level), 64'd0);
        check("drained_valid", 64'(out_valid), 64'd0);
        check("drained_data", out_data, 64'd0);

        // Streaming: one in, one out per cycle for 40 cycles
        out_ready     = 1'b0;
        trace_valid_i = 1'b1;
        trace_data_i  = rec(200);
        step();
        check("stream_prime", 64'(level), 64'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            trace_data_i = rec(201 + c);
            check($sformatf("stream%0d_data", c), out_data, rec(200 + c));
            step();
            check($sformatf("stream%0d_level", c), 64'(level), 64'd1);
        end
        trace_valid_i = 1'b0;
        step();
        check("stream_end_level", 64'(level), 64'd0);

        // Flush: clear, then build level 7 with 3 drops
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush0_ovf", 64'(overflow), 64'd0);
        check("flush0_cnt", 64'(drop_count), 64'd0);
        out_ready     = 1'b0;
        trace_valid_i = 1'b1;
        for (int i = 0; i < 19; i++) begin
            trace_data_i = rec(300 + i);
            step();
        end
        trace_valid_i = 1'b0;
        out_ready     = 1'b1;
        for (int i = 0; i < 9; i++) step();
        check("preflush_level", 64'(level), 64'd7);
        check("preflush_cnt", 64'(drop_count), CNT_EN ? 64'd3 : 64'd0);
        check("preflush_ovf", 64'(overflow), 64'd1);
        check("preflush_head", out_data, rec(309));
        flush         = 1'b1;
        trace_valid_i = 1'b1;
        trace_data_i  = rec(399);
        step();
        flush         = 1'b0;
        trace_valid_i = 1'b0;
        check_all_zero("flush");
        step();
        check("postflush_level", 64'(level), 64'd0);

        // Async reset mid-drain at level 9
        out_ready     = 1'b0;
        trace_valid_i = 1'b1;
        for (int i = 0; i < 11; i++) begin
            trace_data_i = rec(400 + i);
            step();
        end
        trace_valid_i = 1'b0;
        out_ready     = 1'b1;
        step();
        step();
        check("prerst_level", 64'(level), 64'd9);
        check("prerst_head", out_data, rec(402));
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b0;
        trace_valid_i = 1'b1;
        trace_data_i  = rec(500);
        step();
        trace_valid_i = 1'b0;
        check("resume_valid", 64'(out_valid), 64'd1);
        check("resume_data", out_data, rec(500));
        check("resume_level", 64'(level), 64'd1);
        out_ready = 1'b1;
        step();
        check("resume_pop_level", 64'(level), 64'd0);
        check("resume_pop_valid", 64'(out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
